imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream boot loader that writes program words into the 32-bit instruction memory, which the core's fetch path only reads.
- Consumes a framed byte stream from a UART receiver or test host and assembles little-endian 32-bit words.
- Drives the instruction memory write port (4-bit byte-enable, word address, 32-bit data).
- Holds the core in reset until a complete frame with a matching checksum has been written.

Parameters:
- ADDR_W, 8, instruction memory word-address width; depth = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- reload  in  1  one-cycle pulse that restarts loading.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts the byte; a byte transfers when rx_valid & rx_ready.
- imem_we  out  4  instruction memory byte write enables.
- imem_addr  out  ADDR_W  instruction memory word address.
- imem_din  out  32  instruction memory write data.
- core_reset  out  1  reset to the core datapath; 1 = hold.
- load_done  out  1  frame loaded and verified.
- load_error  out  1  frame rejected.
- words_loaded  out  ADDR_W+1  count of words written in the current frame.

Behaviour:
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN*4 data bytes (word 0 first, each word LSB first), then CHK. LEN is a 16-bit word count. CHK = XOR of all data bytes only.
- Reset values: state IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_din=0, core_reset=1, load_done=0, load_error=0, words_loaded=0. Internal byte index, word counter and checksum are cleared.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR. All transitions below occur on accepted bytes only.
  - IDLE: byte == SYNC_BYTE -> LEN_LO. Any other byte is discarded and the FSM stays in IDLE.
  - LEN_LO: latch the low byte -> LEN_HI.
  - LEN_HI: latch the high byte. LEN > 2**ADDR_W -> ERROR. LEN == 0 -> CHECK. Otherwise -> DATA.
  - DATA: shift the byte into the word assembler and XOR it into the running checksum. On the 4th byte of a word, at the next cycle:
    - imem_we=4'hF, imem_addr=word index, imem_din=assembled word, for exactly one cycle;
    - words_loaded increments in that same cycle.
    - After the 4th byte of word LEN-1, go to CHECK.
  - CHECK: byte == running checksum -> DONE, otherwise -> ERROR.
  - DONE: core_reset=0 and load_done=1, starting the cycle after the CHK byte is accepted. Sticky.
  - ERROR: load_error=1, core_reset stays 1. Sticky.
- rx_ready = 1 in IDLE through CHECK, 0 in DONE and ERROR. The loader never stalls for writes: back-to-back bytes are accepted every cycle.
- imem_we is 0 in every cycle other than the word-write cycle. imem_addr and imem_din hold their last values between writes.
- Address never wraps; the LEN bound check guarantees imem_addr stays within 0..2**ADDR_W-1.
- reload (any state) -> IDLE at the next edge:
  - core_reset=1; load_done, load_error, words_loaded, checksum and byte index cleared;
  - imem_we=0 in the following cycle.
  - A byte presented in the same cycle as reload is dropped.
  - A pending word write from the previous cycle still completes.
- reset asserted mid-frame: immediate return to reset values; a partially assembled word is discarded and never written.
- A new SYNC_BYTE is recognised only in IDLE. In DATA, 0xA5 is ordinary data.

Test Plan:
- Nominal load: A5 02 00 13 00 00 00 93 00 10 00 90, one byte per cycle.
  -> writes addr0=0x00000013, then addr1=0x00100093, each with imem_we=4'hF for one cycle;
  -> words_loaded=2;
  -> cycle after byte 90: core_reset=0, load_done=1, rx_ready=0.
- Bad checksum: same frame with CHK=0x91.
  -> both words are still written;
  -> load_error=1, core_reset stays 1, load_done=0, rx_ready=0.
- Noise and zero length: 00 FF A5 00 00 00.
  -> leading noise ignored, no writes, load_done=1, core_reset=0.
- Oversize: A5 01 01 (LEN=257 with ADDR_W=8).
  -> ERROR immediately after LEN_HI, no imem_we activity.
- Reload and reset mid-frame:
  - Pulse reload after 2 data bytes of word 0.
    -> IDLE, core_reset=1, no write;
    -> then a full nominal frame loads correctly.
  - Assert reset after 6 data bytes.
    -> all outputs return to reset values immediately;
    -> word 1 is never written.
- Throttled input: nominal frame with rx_valid low on alternate cycles.
  -> identical memory writes and final state to the nominal case.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The loader is the slave on the byte stream and drives the memory write port.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [3:0]        imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_din;

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_din
    );

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_din
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses SYNC/LEN/data/CHK frames into little-endian words,
// writes them to instruction memory and releases the core on a good frame.
module imem_loader #(
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    imem_loader_if.slave      bus,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t            state_q;
    logic              rx_ready_q;
    logic [3:0]        imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_din_q;
    logic              core_reset_q;
    logic              load_done_q;
    logic              load_error_q;
    logic [ADDR_W:0]   words_loaded_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       word_q;
    logic [7:0]        chk_q;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;

    logic [31:0]       word_d;
    logic [7:0]        chk_d;
    logic [15:0]       len_d;
    logic              last_d;
    logic              accept;

    // Next-word, checksum and length candidates from the byte on the bus.
    always_comb begin
        word_d = {bus.rx_data, word_q};
        chk_d  = chk_q ^ bus.rx_data;
        len_d  = {bus.rx_data, len_lo_q};
        last_d = (16'(words_loaded_q) + 16'd1) == len_q;
        accept = bus.rx_valid & rx_ready_q & ~reload;
    end

    // Frame FSM with registered outputs; reload wins over any byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            rx_ready_q     <= 1'b1;
            imem_we_q      <= '0;
            imem_addr_q    <= '0;
            imem_din_q     <= '0;
            core_reset_q   <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            words_loaded_q <= '0;
            byte_idx_q     <= '0;
            word_q         <= '0;
            chk_q          <= '0;
            len_lo_q       <= '0;
            len_q          <= '0;
        end else begin
            imem_we_q <= '0;
            if (reload) begin
                state_q        <= IDLE;
                rx_ready_q     <= 1'b1;
                core_reset_q   <= 1'b1;
                load_done_q    <= 1'b0;
                load_error_q   <= 1'b0;
                words_loaded_q <= '0;
                byte_idx_q     <= '0;
                chk_q          <= '0;
            end else if (accept) begin
                unique case (state_q)
                    IDLE: begin
                        if (bus.rx_data == SYNC_BYTE) begin
                            state_q        <= LEN_LO;
                            words_loaded_q <= '0;
                            byte_idx_q     <= '0;
                            chk_q          <= '0;
                        end
                    end
                    LEN_LO: begin
                        len_lo_q <= bus.rx_data;
                        state_q  <= LEN_HI;
                    end
                    LEN_HI: begin
                        len_q <= len_d;
                        if ({1'b0, len_d} > DEPTH) begin
                            state_q      <= ERROR;
                            load_error_q <= 1'b1;
                            rx_ready_q   <= 1'b0;
                        end else if (len_d == 16'd0) begin
                            state_q <= CHECK;
                        end else begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        word_q     <= word_d[31:8];
                        chk_q      <= chk_d;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            imem_we_q      <= 4'hF;
                            imem_addr_q    <= words_loaded_q[ADDR_W-1:0];
                            imem_din_q     <= word_d;
                            words_loaded_q <= words_loaded_q
                                            + {{ADDR_W{1'b0}}, 1'b1};
                            if (last_d) begin
                                state_q <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        rx_ready_q <= 1'b0;
                        if (bus.rx_data == chk_q) begin
                            state_q      <= DONE;
                            load_done_q  <= 1'b1;
                            core_reset_q <= 1'b0;
                        end else begin
                            state_q      <= ERROR;
                            load_error_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.imem_we   = imem_we_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.imem_din  = imem_din_q;
    assign core_reset    = core_reset_q;
    assign load_done     = load_done_q;
    assign load_error    = load_error_q;
    assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: frame-level reference model predicts every memory
// write (cycle, address, word) and the final status of each frame.
module tb_imem_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic reset;
    logic reload;
    logic core_reset;
    logic load_done;
    logic load_error;
    logic [AW:0] words_loaded;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .reset        (reset),
        .reload       (reload),
        .bus          (bus),
        .core_reset   (core_reset),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t wlog[$];
    int  n_vec = 0;
    int  n_miss = 0;
    int  gap_pct = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare of the write port against the predicted writes.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                n_vec++;
                n_miss++;
                $display("FAIL missed_write: got no write expected addr %0d data %h at cycle %0d",
                         exp_q[0].addr, exp_q[0].data, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
                chk("we_write", 32'(bus.imem_we), 32'hF);
                chk("addr", 32'(bus.imem_addr), 32'(exp_q[0].addr));
                chk("din", bus.imem_din, exp_q[0].data);
                wlog.push_back('{cyc, bus.imem_addr, bus.imem_din});
                void'(exp_q.pop_front());
            end else begin
                chk("we_idle", 32'(bus.imem_we), 32'h0);
            end
            chk("core_reset_vs_done", 32'(core_reset), 32'(!load_done));
            chk("ready_vs_status", 32'(bus.rx_ready),
                32'(!(load_done || load_error)));
        end
    end

    task automatic idle_cycle();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, output int c);
        if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) idle_cycle();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        c = cyc;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'($urandom);
    endtask

    task automatic send_frame(input int len, input logic [7:0] data[$],
                              input logic [7:0] chk_xor, input int noise,
                              input int stop_after, output bit exp_done,
                              output bit exp_err, output int exp_words);
        int c;
        logic [7:0] r;
        logic [7:0] x;
        logic [31:0] w;
        logic [15:0] l16;
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_words = 0;
        l16 = 16'(len);
        for (int k = 0; k < noise; k++) begin
            do r = 8'($urandom); while (r == 8'hA5);
            put(r, c);
        end
        put(8'hA5, c);
        put(l16[7:0], c);
        put(l16[15:8], c);
        if (len > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        w = 32'h0;
        for (int i = 0; i < data.size(); i++) begin
            put(data[i], c);
            x ^= data[i];
            w = {data[i], w[31:8]};
            if (i % 4 == 3) begin
                exp_q.push_back('{c + 1, 8'(i / 4), w});
                exp_words++;
            end
            if (i + 1 == stop_after) return;
        end
        put(x ^ chk_xor, c);
        exp_done = (chk_xor == 8'h00);
        exp_err  = (chk_xor != 8'h00);
    endtask

    task automatic check_end(input string nm, input bit ed, input bit ee,
                             input int ew);
        @(negedge clk);
        chk({nm, "_done"}, 32'(load_done), 32'(ed));
        chk({nm, "_error"}, 32'(load_error), 32'(ee));
        chk({nm, "_core_reset"}, 32'(core_reset), 32'(!ed));
        chk({nm, "_rx_ready"}, 32'(bus.rx_ready), 32'(!(ed || ee)));
        chk({nm, "_words"}, 32'(words_loaded), 32'(ew));
        chk({nm, "_pending"}, 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reload(input bit with_byte);
        bus.rx_valid = with_byte;
        bus.rx_data  = 8'hA5;
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        chk("reload_core_reset", 32'(core_reset), 32'd1);
        chk("reload_done", 32'(load_done), 32'd0);
        chk("reload_error", 32'(load_error), 32'd0);
        chk("reload_words", 32'(words_loaded), 32'd0);
        chk("reload_ready", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_din", bus.imem_din, 32'd0);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_ready", 32'(bus.rx_ready), 32'd1);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_error", 32'(load_error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] nom[$];
    logic [7:0] d[$];
    bit ed;
    bit ee;
    int ew;
    int len;

    initial begin
        nom = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        reset = 1'b0;
        reload = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        #2;
        do_reset();

        wlog.delete();
        send_frame(2, nom, 8'h00, 0, -1, ed, ee, ew);
        check_end("nominal", ed, ee, ew);
        chk("nom_nwrites", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            chk("nom_w0_addr", 32'(wlog[0].addr), 32'd0);
            chk("nom_w0_data", wlog[0].data, 32'h00000013);
            chk("nom_w1_addr", 32'(wlog[1].addr), 32'd1);
            chk("nom_w1_data", wlog[1].data, 32'h00100093);
        end
        do_reload(1'b1);

        wlog.delete();
        send_frame(2, nom, 8'h01, 0, -1, ed, ee, ew);
        check_end("bad_chk", ed, ee, ew);
        chk("bad_chk_literal_error", 32'(load_error), 32'd1);
        chk("bad_chk_nwrites", 32'(wlog.size()), 32'd2);
        do_reload(1'b0);

        d.delete();
        wlog.delete();
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h00;
        @(posedge clk);
        #1;
        bus.rx_data = 8'hFF;
        @(posedge clk);
        #1;
        send_frame(0, d, 8'h00, 0, -1, ed, ee, ew);
        check_end("zero_len", ed, ee, ew);
        chk("zero_len_literal_done", 32'(load_done), 32'd1);
        chk("zero_len_nwrites", 32'(wlog.size()), 32'd0);
        do_reload(1'b0);

        send_frame(257, d, 8'h00, 0, -1, ed, ee, ew);
        check_end("oversize", ed, ee, ew);
        do_reload(1'b0);

        d.delete();
        for (int i = 0; i < 1024; i++) d.push_back(8'($urandom));
        wlog.delete();
        send_frame(256, d, 8'h00, 0, -1, ed, ee, ew);
        check_end("len256", ed, ee, ew);
        chk("len256_words_literal", 32'(words_loaded), 32'd256);
        if (wlog.size() != 0) begin
            chk("len256_last_addr", 32'(wlog[wlog.size() - 1].addr), 32'd255);
        end
        do_reload(1'b0);

        send_frame(2, nom, 8'h00, 0, 2, ed, ee, ew);
        do_reload(1'b1);
        send_frame(2, nom, 8'h00, 0, -1, ed, ee, ew);
        check_end("after_reload", ed, ee, ew);
        do_reload(1'b0);

        wlog.delete();
        send_frame(2, nom, 8'h00, 0, 6, ed, ee, ew);
        do_reset();
        repeat (4) idle_cycle();
        chk("reset_mid_nwrites", 32'(wlog.size()), 32'd1);
        send_frame(2, nom, 8'h00, 0, -1, ed, ee, ew);
        check_end("after_reset", ed, ee, ew);
        do_reload(1'b0);

        gap_pct = 50;
        send_frame(2, nom, 8'h00, 1, -1, ed, ee, ew);
        check_end("throttled", ed, ee, ew);
        do_reload(1'b0);

        for (int t = 0; t < 40; t++) begin
            gap_pct = int'($urandom_range(2)) * 30;
            if ($urandom_range(9) == 0) len = 257 + int'($urandom_range(65278));
            else len = int'($urandom_range(5));
            d.delete();
            if (len <= (1 << AW)) begin
                for (int i = 0; i < len * 4; i++) d.push_back(8'($urandom));
            end
            send_frame(len, d,
                       ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'h00,
                       int'($urandom_range(3)), -1, ed, ee, ew);
            check_end("random", ed, ee, ew);
            do_reload(1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
